barcode_rx_param: RTL

//  Parametrised self-timed barcode receiver for the follower line-station reader.

---
 rtl/barcode_rx_param.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/barcode_rx_param.sv
// Self-timed barcode receiver: learns the bit time from the start bit and decodes ID_W bits MSB first.
// Define BARCODE_PARITY_EN to expect one trailing even-parity bit per frame.
module barcode_rx_param #(
    parameter int ID_W     = 8,
    parameter int PREFIX_W = 2,
    parameter int TMR_W    = 22,
    parameter int TO_MULT  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            BC,
    input  logic            clr_ID_vld,
    output logic [ID_W-1:0] ID,
    output logic            ID_vld,
    output logic            frame_err
);

`ifdef BARCODE_PARITY_EN
    localparam int NBITS = ID_W + 1;
`else
    localparam int NBITS = ID_W;
`endif
    localparam int TO_W  = TMR_W + $clog2(TO_MULT + 1);
    localparam int BCN_W = $clog2(NBITS + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_FALL, SAMPLE, CHECK} state_t;
    state_t state, state_nxt;

    logic             bc_s1, bc_s2, bc_s3;
    logic             fall, rise;
    logic [TO_W-1:0]  cnt;
    logic [TO_W-1:0]  to_limit;
    logic [TMR_W-1:0] t_s;
    logic [NBITS-1:0] shreg;
    logic [BCN_W-1:0] bit_cnt;
    logic [ID_W-1:0]  id_bits;
    logic             cnt_sat, prefix_ok, parity_ok;
    logic             cnt_clr, cnt_inc, ts_load, shift_en, accept, err_set, bits_clr;

    assign fall     = bc_s3 & ~bc_s2;
    assign rise     = ~bc_s3 & bc_s2;
    assign cnt_sat  = (cnt[TMR_W-1:0] == {TMR_W{1'b1}});
    assign to_limit = TO_W'(t_s) * TO_W'(TO_MULT);

`ifdef BARCODE_PARITY_EN
    assign id_bits   = shreg[NBITS-1:1];
    assign parity_ok = ~(^shreg);
`else
    assign id_bits   = shreg;
    assign parity_ok = 1'b1;
`endif

    generate
        if (PREFIX_W == 0) begin : g_no_prefix
            assign prefix_ok = 1'b1;
        end else begin : g_prefix
            assign prefix_ok = (id_bits[ID_W-1 -: PREFIX_W] == '0);
        end
    endgenerate

    // Next state and datapath controls; the counter is reused for start-bit timing, sampling and timeout
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        ts_load   = 1'b0;
        shift_en  = 1'b0;
        accept    = 1'b0;
        err_set   = 1'b0;
        bits_clr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    cnt_clr   = 1'b1;
                    bits_clr  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (rise) begin
                    if (cnt < TO_W'(2)) begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ts_load   = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = WAIT_FALL;
                    end
                end else if (cnt_sat) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_FALL: begin
                if (fall) begin
                    cnt_clr   = 1'b1;
                    state_nxt = SAMPLE;
                end else if (cnt >= to_limit) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt == TO_W'(t_s)) begin
                    shift_en  = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = (bit_cnt == BCN_W'(NBITS - 1)) ? CHECK : WAIT_FALL;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                if (prefix_ok && parity_ok) begin
                    accept = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bc_s1     <= 1'b1;
            bc_s2     <= 1'b1;
            bc_s3     <= 1'b1;
            cnt       <= '0;
            t_s       <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            ID        <= '0;
            ID_vld    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_nxt;
            bc_s1 <= BC;
            bc_s2 <= bc_s1;
            bc_s3 <= bc_s2;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + TO_W'(1);
            end
            if (ts_load) begin
                t_s <= cnt[TMR_W-1:0];
            end
            if (bits_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + BCN_W'(1);
            end
            if (shift_en) begin
                shreg <= {shreg[NBITS-2:0], bc_s2};
            end
            frame_err <= err_set;
            // An accept outranks a simultaneous clear
            if (accept) begin
                ID     <= id_bits;
                ID_vld <= 1'b1;
            end else if (clr_ID_vld) begin
                ID_vld <= 1'b0;
            end
        end
    end

endmodule
